imem_loader: RTL and testbench

Boot-time writer for the instruction RAM of the single-cycle RV32I core. Accepts a byte stream on a valid/ready handshake, assembles little-endian 32-bit words, and drives the RAM write port (`we`/`din`/`addre`) that the core only ever reads. Holds the core in reset while loading and releases it when the image is complete.

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: boot-time writer for the RV32I instruction RAM.
// Receives a length-prefixed little-endian byte image on a valid/ready
// stream, writes one 32-bit word per WRITE cycle and keeps the core in
// reset until the whole image has landed.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the core is released.
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state;
    logic [1:0]  bcnt;
    logic [31:0] len_sr;
    logic [31:0] word_sr;
    logic [31:0] k;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        fire;
    logic [31:0] len_next;
    logic [31:0] word_next;
    logic [31:0] k_next;

    // Byte transfer qualifier and the shift-in views of the assemblers.
    always_comb begin
        fire      = rx_valid && rx_ready;
        len_next  = {rx_data, len_sr[31:8]};
        word_next = {rx_data, word_sr[31:8]};
        k_next    = k + 32'd1;
    end

    // Length/data assembly registers carry no control meaning and need no reset.
    always_ff @(posedge clk) begin
        if (fire && state == S_LEN)  len_sr  <= len_next;
        if (fire && state == S_DATA) word_sr <= word_next;
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= ADDR_BASE;
            mem_wdata  <= 32'h0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            bcnt       <= 2'd0;
            k          <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        rx_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        core_reset <= 1'b1;
                        bcnt       <= 2'd0;
                        k          <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= 8'h00;
`endif
                    end
                end

                S_LEN: begin
                    if (fire) begin
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            if (len_next > DEPTH_W) begin
                                state      <= S_ERR;
                                rx_ready   <= 1'b0;
                                busy       <= 1'b0;
                                error      <= 1'b1;
                                core_reset <= 1'b1;
                            end else if (len_next == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                // Empty image still carries a checksum byte (expected 0).
                                state <= S_CSUM;
`else
                                state      <= S_DONE;
                                rx_ready   <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                core_reset <= 1'b0;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (fire) begin
                        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (bcnt == 2'd3) begin
                            // Write strobe, address and data all launch together
                            // so the RAM sees them stable through WRITE.
                            state     <= S_WRITE;
                            rx_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_BASE + {k[29:0], 2'b00};
                            mem_wdata <= word_next;
                        end
                    end
                end

                S_WRITE: begin
                    k <= k_next;
                    if (k_next == len_sr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= S_CSUM;
                        rx_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_reset <= 1'b0;
`endif
                    end else begin
                        state    <= S_DATA;
                        rx_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (fire) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == csum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state      <= S_ERR;
                            error      <= 1'b1;
                            core_reset <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state    <= S_IDLE;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Directed bench for imem_loader: basic load, bubbles, oversize and
// 32-bit length handling, empty image, reset mid-load and (with the
// checksum macro) checksum match/mismatch.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_n     = 0;
    int          rdy_bad  = 0;
    int          both_bad = 0;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    logic [7:0]  xsum;
    bit          gap = 1'b0;

    // Write log taken on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 32) begin
                wr_addr[wr_n] <= mem_addr;
                wr_data[wr_n] <= mem_wdata;
            end
            wr_n <= wr_n + 1;
            if (rx_ready) rdy_bad <= rdy_bad + 1;
        end
        if (done && error) both_bad <= both_bad + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        bit r;
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!sent && t < 40) begin
            r = rx_ready;
            @(posedge clk);
            #1;
            sent = r;
            t++;
        end
        if (!sent) begin
            n_checks++;
            $error("FAIL rx_timeout: byte 0x%02h not accepted, expected acceptance within 40 cycles", b);
        end
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hA5;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            xsum = xsum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic do_start();
        rx_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xsum  = 8'h00;
    endtask

    task automatic pulse_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int base;
    int rbase;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        xsum     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",   32'(rx_ready),   32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   mem_addr,        32'h0);
        check("rst_mem_wdata",  mem_wdata,       32'h0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rx_ready", 32'(rx_ready), 32'd0);

        // Basic back-to-back load of two words.
        base = wr_n;
        do_start();
        check("b_busy",     32'(busy),     32'd1);
        check("b_rx_ready", 32'(rx_ready), 32'd1);
        send_len(32'd2);
        send_word(32'h00500093);
        send_word(32'h00108113);
        check("b_we2",    32'(mem_we),   32'd1);
        check("b_addr2",  mem_addr,      32'h4);
        check("b_data2",  mem_wdata,     32'h00108113);
        check("b_wr_rdy", 32'(rx_ready), 32'd0);
        check("b_notdone",32'(done),     32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum);
`else
        @(posedge clk);
        #1;
`endif
        rx_valid = 1'b0;
        check("b_done",       32'(done),       32'd1);
        check("b_core_reset", 32'(core_reset), 32'd0);
        check("b_busy_end",   32'(busy),       32'd0);
        check("b_error",      32'(error),      32'd0);
        check("b_nwrites",    32'(wr_n - base), 32'd2);
        check("b_addr0",      wr_addr[base],     32'h0);
        check("b_data0",      wr_data[base],     32'h00500093);
        check("b_addr1",      wr_addr[base + 1], 32'h4);
        check("b_data1",      wr_data[base + 1], 32'h00108113);

        // Same image with rx_valid toggling every other cycle.
        base  = wr_n;
        rbase = rdy_bad;
        gap   = 1'b1;
        do_start();
        check("g_core_reset_re", 32'(core_reset), 32'd1);
        check("g_done_clr",      32'(done),       32'd0);
        send_len(32'd2);
        send_word(32'h00500093);
        send_word(32'h00108113);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum);
`endif
        gap      = 1'b0;
        rx_valid = 1'b0;
        check("g_done",       32'(done),        32'd1);
        check("g_core_reset", 32'(core_reset),  32'd0);
        check("g_nwrites",    32'(wr_n - base), 32'd2);
        check("g_addr0",      wr_addr[base],     32'h0);
        check("g_data0",      wr_data[base],     32'h00500093);
        check("g_addr1",      wr_addr[base + 1], 32'h4);
        check("g_data1",      wr_data[base + 1], 32'h00108113);
        check("g_rdy_in_write", 32'(rdy_bad - rbase), 32'd0);

        // Oversize length, one past DEPTH.
        base = wr_n;
        do_start();
        send_len(32'd1025);
        rx_valid = 1'b0;
        check("o_error",      32'(error),      32'd1);
        check("o_core_reset", 32'(core_reset), 32'd1);
        check("o_done",       32'(done),       32'd0);
        check("o_busy",       32'(busy),       32'd0);
        check("o_rx_ready",   32'(rx_ready),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("o_nwrites",    32'(wr_n - base), 32'd0);

        // Length with only the top byte set must use the full 32 bits.
        do_start();
        check("h_error_clr", 32'(error), 32'd0);
        send_len(32'h0100_0000);
        rx_valid = 1'b0;
        check("h_error", 32'(error), 32'd1);

        // Exactly DEPTH is accepted; start while loading is ignored.
        do_start();
        send_len(32'd1024);
        rx_valid = 1'b0;
        check("d_busy",     32'(busy),     32'd1);
        check("d_rx_ready", 32'(rx_ready), 32'd1);
        check("d_error",    32'(error),    32'd0);
        do_start();
        check("d_start_ign", 32'(rx_ready), 32'd1);
        pulse_reset();

        // Empty image.
        base = wr_n;
        do_start();
        send_len(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        rx_valid = 1'b0;
        check("e_done",       32'(done),       32'd1);
        check("e_core_reset", 32'(core_reset), 32'd0);
        check("e_nwrites",    32'(wr_n - base), 32'd0);

        // Reset after six data bytes, then a fresh single-word load.
        base = wr_n;
        do_start();
        send_len(32'd2);
        send_word(32'hCAFEF00D);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_reset();
        check("r_rx_ready",   32'(rx_ready),   32'd0);
        check("r_mem_we",     32'(mem_we),     32'd0);
        check("r_mem_addr",   mem_addr,        32'h0);
        check("r_mem_wdata",  mem_wdata,       32'h0);
        check("r_core_reset", 32'(core_reset), 32'd1);
        check("r_busy",       32'(busy),       32'd0);
        check("r_done",       32'(done),       32'd0);
        check("r_error",      32'(error),      32'd0);
        check("r_nwrites",    32'(wr_n - base), 32'd1);
        base = wr_n;
        do_start();
        send_len(32'd1);
        send_word(32'hDEADBEEF);
        check("r2_we",   32'(mem_we), 32'd1);
        check("r2_addr", mem_addr,    32'h0);
        check("r2_data", mem_wdata,   32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum);
`else
        @(posedge clk);
        #1;
`endif
        rx_valid = 1'b0;
        check("r2_done",       32'(done),        32'd1);
        check("r2_core_reset", 32'(core_reset),  32'd0);
        check("r2_nwrites",    32'(wr_n - base), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum of 11^22^33^44 is 8'h44.
        do_start();
        send_len(32'd1);
        send_word(32'h11223344);
        send_byte(8'h44);
        rx_valid = 1'b0;
        check("c_ok_done",       32'(done),       32'd1);
        check("c_ok_core_reset", 32'(core_reset), 32'd0);
        do_start();
        send_len(32'd1);
        send_word(32'h11223344);
        send_byte(8'h45);
        rx_valid = 1'b0;
        check("c_bad_error",      32'(error),      32'd1);
        check("c_bad_done",       32'(done),       32'd0);
        check("c_bad_core_reset", 32'(core_reset), 32'd1);
`endif

        check("done_error_excl", 32'(both_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
